// File: rtl/sel_change_highlight.sv
// sel_change_highlight
//   Watches NCH packed selector codes. When exactly one channel changes, that
//   channel's segment is highlighted for HOLD cycles. Every other segment is
//   blanked during that time. When no highlight is active, all segments are lit.
//   When two or more channels change in the same cycle, the block goes back to
//   all-lit.
//
// Ports
//   I_CLK   in   1            sole clock, rising edge
//   I_RST   in   1            synchronous active-high reset
//   I_SEL   in   NCH*W        selector codes, channel k at [k*W +: W]
//   O_SEG   out  NCH          segment enables, active-high (registered)
//   O_BUSY  out  1            high while highlighting (registered)
//   O_CH    out  clog2(NCH)   highlighted channel index (registered)
//
// Optional feature: define DIFF_BLINK_EN to make the highlighted segment
// blink with a half-period of BLINK_HALF cycles, starting in the on phase.
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | no highlight, all segments on
// HIGHLIGHT | one channel shown, CNT counts the remaining hold cycles

module sel_change_highlight #(
  parameter int NCH        = 2,
  parameter int W          = 3,
  parameter int HOLD       = 1000,
  parameter int BLINK_HALF = 250
) (
  input  logic                                  I_CLK,
  input  logic                                  I_RST,
  input  logic [NCH*W-1:0]                      I_SEL,
  output logic [NCH-1:0]                        O_SEG,
  output logic                                  O_BUSY,
  output logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] O_CH
);

  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int CW  = (HOLD > 1) ? $clog2(HOLD) : 1;

  if (NCH < 2 || W < 1 || HOLD < 1 || BLINK_HALF < 1) begin : g_bad_param
    $error("sel_change_highlight: illegal parameter value");
  end

  typedef enum logic {
    IDLE      = 1'b0,
    HIGHLIGHT = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [NCH*W-1:0] prev;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [CHW-1:0]   ch_nxt;
  logic [NCH-1:0]   seg_nxt;
  logic [NCH-1:0]   chg;
  logic             chg_any, chg_multi;
  logic [CHW-1:0]   chg_idx;
  logic             lit;

`ifdef DIFF_BLINK_EN
  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  logic          phase, phase_nxt;
  logic [BW-1:0] bcnt, bcnt_nxt;
`endif

  // Single pass over the change vector gives "any", "more than one" and the
  // index of the single changed channel without needing a popcount.
  always_comb begin
    chg       = '0;
    chg_any   = 1'b0;
    chg_multi = 1'b0;
    chg_idx   = '0;
    for (int k = 0; k < NCH; k++) begin
      chg[k] = (I_SEL[k*W +: W] != prev[k*W +: W]);
      if (chg[k]) begin
        if (chg_any) chg_multi = 1'b1;
        chg_any = 1'b1;
        chg_idx = CHW'(k);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ch_nxt    = O_CH;
    lit       = 1'b1;
`ifdef DIFF_BLINK_EN
    phase_nxt = phase;
    bcnt_nxt  = bcnt;
`endif
    if (chg_multi) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else if (chg_any) begin
      state_nxt = HIGHLIGHT;
      cnt_nxt   = CW'(HOLD - 1);
      ch_nxt    = chg_idx;
`ifdef DIFF_BLINK_EN
      phase_nxt = 1'b1;
      bcnt_nxt  = BW'(BLINK_HALF - 1);
`endif
    end else if (state == HIGHLIGHT) begin
      if (cnt == '0) begin
        state_nxt = IDLE;
      end else begin
        cnt_nxt = cnt - 1'b1;
      end
`ifdef DIFF_BLINK_EN
      if (bcnt == '0) begin
        phase_nxt = ~phase;
        bcnt_nxt  = BW'(BLINK_HALF - 1);
      end else begin
        bcnt_nxt = bcnt - 1'b1;
      end
`endif
    end else begin
      cnt_nxt = '0;
    end

`ifdef DIFF_BLINK_EN
    lit = phase_nxt;
`endif

    seg_nxt = '1;
    if (state_nxt == HIGHLIGHT) begin
      for (int k = 0; k < NCH; k++) begin
        seg_nxt[k] = lit && (ch_nxt == CHW'(k));
      end
    end
  end

  always_ff @(posedge I_CLK) begin
    prev <= I_SEL;
    if (I_RST) begin
      state  <= IDLE;
      cnt    <= '0;
      O_SEG  <= '1;
      O_BUSY <= 1'b0;
      O_CH   <= '0;
`ifdef DIFF_BLINK_EN
      phase  <= 1'b1;
      bcnt   <= '0;
`endif
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      O_SEG  <= seg_nxt;
      O_BUSY <= (state_nxt == HIGHLIGHT);
      O_CH   <= ch_nxt;
`ifdef DIFF_BLINK_EN
      phase  <= phase_nxt;
      bcnt   <= bcnt_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_sel_change_highlight.sv
module tb_sel_change_highlight;
  localparam int NCH = 2;
  localparam int W   = 3;
  localparam int HOLD = 4;
  localparam int BH  = 2;

  logic       I_CLK = 1'b0;
  logic       I_RST;
  logic [5:0] I_SEL;
  logic [1:0] O_SEG;
  logic       O_BUSY;
  logic       O_CH;

  typedef struct {
    logic [1:0] seg;
    logic       busy;
    logic       ch;
    string      tag;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  sel_change_highlight #(.NCH(NCH), .W(W), .HOLD(HOLD), .BLINK_HALF(BH)) dut (
    .I_CLK (I_CLK),
    .I_RST (I_RST),
    .I_SEL (I_SEL),
    .O_SEG (O_SEG),
    .O_BUSY(O_BUSY),
    .O_CH  (O_CH)
  );

  always #5 I_CLK = ~I_CLK;

  // Expected segment pattern for channel ch, age cycles after the highlight
  // was (re)started.
  function automatic logic [1:0] exp_hl(input int ch, input int age);
    logic [1:0] s;
    s = (ch == 0) ? 2'b01 : 2'b10;
`ifdef DIFF_BLINK_EN
    if (((age / BH) % 2) != 0) s = 2'b00;
`else
    if (age < 0) s = 2'b00;
`endif
    return s;
  endfunction

  task automatic check_out();
    exp_t e;
    tests++;
    assert (q.size() > 0) else begin
      fails++;
      $error("FAIL scoreboard_empty observed=%0d expected=1", q.size());
    end
    if (q.size() > 0) begin
      e = q.pop_front();
      tests++;
      assert (O_SEG === e.seg) else begin
        fails++;
        $error("FAIL %s seg observed=%b expected=%b", e.tag, O_SEG, e.seg);
      end
      tests++;
      assert (O_BUSY === e.busy) else begin
        fails++;
        $error("FAIL %s busy observed=%b expected=%b", e.tag, O_BUSY, e.busy);
      end
      tests++;
      assert (O_CH === e.ch) else begin
        fails++;
        $error("FAIL %s ch observed=%b expected=%b", e.tag, O_CH, e.ch);
      end
    end
  endtask

  task automatic step(input logic rst, input logic [5:0] sel, input logic [1:0] seg,
                      input logic busy, input logic ch, input string tag);
    exp_t e;
    @(negedge I_CLK);
    I_RST = rst;
    I_SEL = sel;
    e.seg = seg; e.busy = busy; e.ch = ch; e.tag = tag;
    q.push_back(e);
    @(posedge I_CLK);
    #1;
    check_out();
  endtask

  task automatic idle(input logic [5:0] sel, input logic ch, input string tag);
    step(1'b0, sel, 2'b11, 1'b0, ch, tag);
  endtask

  task automatic hl(input logic [5:0] sel, input int ch, input int age, input string tag);
    step(1'b0, sel, exp_hl(ch, age), 1'b1, ch[0], tag);
  endtask

  initial begin
    I_RST = 1'b1;
    I_SEL = 6'o12;
    step(1'b1, 6'o12, 2'b11, 1'b0, 1'b0, "reset0");
    step(1'b1, 6'o12, 2'b11, 1'b0, 1'b0, "reset1");
    for (int i = 0; i < 10; i++) idle(6'o12, 1'b0, "stable");

    // single change on channel 0, full hold then timeout
    for (int a = 0; a < HOLD; a++) hl(6'o15, 0, a, "ch0_hold");
    idle(6'o15, 1'b0, "ch0_expire");
    idle(6'o15, 1'b0, "ch0_idle");

    // channel 1 change, retrigger two cycles later
    hl(6'o25, 1, 0, "ch1_first");
    hl(6'o25, 1, 1, "ch1_first");
    for (int a = 0; a < HOLD; a++) hl(6'o35, 1, a, "ch1_retrig");
    idle(6'o35, 1'b1, "ch1_expire");

    // channel 0 then switch to channel 1 mid-highlight
    hl(6'o36, 0, 0, "ch0_after");
    hl(6'o36, 0, 1, "ch0_after");
    hl(6'o46, 1, 0, "switch_ch1");
    hl(6'o46, 1, 1, "switch_ch1");

    // both channels change: mid-highlight, then from idle
    idle(6'o57, 1'b1, "multi_mid");
    idle(6'o57, 1'b1, "multi_mid_hold");
    idle(6'o60, 1'b1, "multi_idle");
    idle(6'o60, 1'b1, "multi_idle_hold");

    // reset pulse mid-highlight, input changes while in reset
    hl(6'o70, 1, 0, "pre_rst");
    hl(6'o70, 1, 1, "pre_rst");
    step(1'b1, 6'o72, 2'b11, 1'b0, 1'b0, "rst_abort");
    idle(6'o72, 1'b0, "post_rst");
    idle(6'o72, 1'b0, "post_rst");
    hl(6'o73, 0, 0, "after_rst_chg");
    for (int a = 1; a < HOLD; a++) hl(6'o73, 0, a, "after_rst_chg");
    idle(6'o73, 1'b0, "final_idle");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/sel_change_highlight.md
SEL_CHANGE_HIGHLIGHT -- requirements
Module: sel_change_highlight

Interface
REQ-001 SHALL have parameter NCH, default 2, number of selector channels (>=2).
REQ-002 SHALL have parameter W, default 3, selector code width per channel (>=1).
REQ-003 SHALL have parameter HOLD, default 1000, highlight duration in clock cycles (>=1).
REQ-004 SHALL have parameter BLINK_HALF, default 250, blink half-period in cycles (>=1; used only under DIFF_BLINK_EN).
REQ-005 SHALL have port I_CLK  input  1  sole clock; all state updates on its rising edge.
REQ-006 SHALL have port I_RST  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port I_SEL  input  NCH*W  packed selector codes; channel k at bits [k*W +: W]; synchronous to I_CLK, no internal synchroniser.
REQ-008 SHALL have port O_SEG  output  NCH  segment enables, active-high, bit k = channel k; registered.
REQ-009 SHALL have port O_BUSY  output  1  high while in HIGHLIGHT state; registered.
REQ-010 SHALL have port O_CH  output  $clog2(NCH) (min 1)  index of highlighted channel; registered.

Function
REQ-011 SHALL hold register PREV (NCH*W), loaded with I_SEL every cycle.
REQ-012 SHALL compute per-channel change vector CHG[k] = (I_SEL channel k != PREV channel k).
REQ-013 SHALL implement two states: IDLE and HIGHLIGHT.
REQ-014 IDLE: O_SEG = all ones, O_BUSY = 0, O_CH holds last value.
REQ-015 Exactly one CHG bit set (channel j), any state -> next state HIGHLIGHT, O_CH = j, counter CNT = HOLD-1, O_SEG = one-hot j.
REQ-016 Same channel as O_CH changes again during HIGHLIGHT -> CNT reloaded to HOLD-1 (retrigger).
REQ-017 Different single channel changes during HIGHLIGHT -> switch O_CH and O_SEG to the new channel, CNT reloaded.
REQ-018 Two or more CHG bits set in one cycle, any state -> next state IDLE, O_SEG all ones, CNT cleared.
REQ-019 HIGHLIGHT with no CHG: CNT decrements each cycle; at CNT==0 with no CHG -> IDLE next cycle.
REQ-020 Latency: input change sampled at edge n appears on O_SEG/O_BUSY/O_CH after edge n (one register stage); highlight lasts exactly HOLD cycles absent further changes.
REQ-021 CNT width SHALL be $clog2(HOLD) (min 1); no wrap below zero.
REQ-022 Priority per cycle: reset > multi-change > single-change > countdown.

Reset
REQ-023 While I_RST=1: PREV <= I_SEL, state IDLE, CNT=0, O_SEG all ones, O_BUSY=0, O_CH=0, blink phase reset.
REQ-024 Reset asserted mid-HIGHLIGHT SHALL abort on the next edge; first cycle after reset release SHALL report no change unless I_SEL differs from the value sampled during reset.

Configuration
REQ-025 Macro DIFF_BLINK_EN defined: in HIGHLIGHT, highlighted O_SEG bit toggles every BLINK_HALF cycles, starting on; other bits 0; blink phase restarts on each entry/retrigger/switch; IDLE unaffected.
REQ-026 Macro DIFF_BLINK_EN undefined: highlighted bit steady 1; no blink counter or BLINK_HALF logic synthesised.

Verification (NCH=2, W=3, HOLD=4, BLINK_HALF=2)
REQ-027 Reset with I_SEL=6'o12, release, hold stable 10 cycles -> O_SEG=2'b11, O_BUSY=0 throughout.
REQ-028 Channel 0 code 2->5 at edge n -> O_SEG=2'b01, O_CH=0, O_BUSY=1 for edges n..n+3; 2'b11, O_BUSY=0 from edge n+4.
REQ-029 Channel 1 changes, then channel 1 changes again 2 cycles later -> highlight extends to 4 cycles after second change; then channel 0 changes -> O_SEG=2'b01, O_CH=0 next edge.
REQ-030 Both channels change same cycle (idle and mid-highlight cases) -> O_SEG=2'b11, O_BUSY=0 next edge.
REQ-031 I_RST pulsed 1 cycle mid-HIGHLIGHT -> O_SEG=2'b11, O_BUSY=0, O_CH=0 after that edge; no spurious highlight after release.
REQ-032 DIFF_BLINK_EN defined, channel 1 change -> O_SEG sequence 10,10,00,00 then 11.
